// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store initiator.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} mau_state_e;

  // An illegal size is reported through the same error path as misalignment.
  function automatic logic misaligned(size_e size, logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the ram-side bus of the load/store unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // The unit itself.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  // Requester and ram side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte/halfword lane extraction for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Little-endian lane select; untouched bytes of the stored word are preserved.
  always_comb begin
    o_load_data  = i_word;
    o_store_word = i_word;
    case (i_size)
      SZ_B: begin
        o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
        o_store_word[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_H: begin
        o_load_data = {{16{i_signed & w_half[15]}}, w_half};
        if (i_offset[1]) o_store_word[31:16] = i_wdata[15:0];
        else             o_store_word[15:0]  = i_wdata[15:0];
      end
      default: begin
        o_load_data  = i_word;
        o_store_word = i_wdata;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data ram.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);
  mau_state_e        r_state;
  logic              r_write;
  size_e             r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [ADDR_W-1:0] w_shift;
  logic [31:0]       w_word_idx;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_word;
  size_e             w_req_size;

  assign w_req_size = size_e'(bus.req_size);
  assign w_shift    = bus.req_addr >> 2;
  assign w_word_idx = 32'(w_shift);

  // Lane logic works on ram data directly; it is only consumed on the last RD edge.
  mem_lane_align u_lane (
    .i_word       (bus.mem_rdata),
    .i_size       (r_size),
    .i_offset     (r_off),
    .i_signed     (r_signed),
    .i_wdata      (r_wdata[31:0]),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_size      <= SZ_B;
      r_signed    <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_write     <= bus.req_write;
            r_size      <= w_req_size;
            r_signed    <= bus.req_signed;
            r_off       <= bus.req_addr[1:0];
            r_wdata     <= DATA_W'(bus.req_wdata);
            r_req_ready <= 1'b0;
            r_mem_addr  <= w_word_idx;
            if (misaligned(w_req_size, bus.req_addr[1:0])) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (bus.req_write && (w_req_size == SZ_W)) begin
              r_state     <= WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state <= RD;
              r_cnt   <= 8'(RD_LAT - 1);
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        RD: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (r_write) begin
            r_state     <= WR;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_store_word;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load_data;
          end
        end
        WR: begin
          r_state     <= RESP;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset abort and random requests vs a reference model.
module tb_mem_access_unit;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) bus();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 16-word ram with combinational read (one cycle from a registered address).
  logic [31:0] ram [16];
  logic [31:0] ref_mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_val = 32'd0;
  int          we_total = 0;

  assign bus.mem_rdata = ram[bus.mem_addr[3:0]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
      we_total <= we_total + 1;
    end
    if (pre_en) ram[pre_idx] <= pre_val;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preset(input logic [3:0] i, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = i; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[i] = v;
  endtask

  // Reference behaviour derived from the lane/alignment rules.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic [31:0] nw);
    int off, sh;
    logic [31:0] mask, v, top;
    off  = int'(a[1:0]);
    sh   = 8 * off;
    mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    top  = (sz == 2'd0) ? 32'h0000_0080 : 32'h0000_8000;
    er   = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    rd   = 32'd0;
    nw   = word;
    if (er) begin
      lat = 1;
    end else if (w) begin
      if (sz == 2'd2) begin
        nw = wd; lat = 2;
      end else begin
        nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
        lat = RD_LAT + 2;
      end
    end else begin
      lat = RD_LAT + 1;
      if (sz == 2'd2) rd = word;
      else begin
        v = (word >> sh) & mask;
        if (sg && ((v & top) != 0)) v = v | ~mask;
        rd = v;
      end
    end
  endtask

  // Issue one request (called at a negedge with the unit idle) and check the protocol.
  task automatic run_req(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] o_rd, output logic o_err, output int o_lat);
    logic [31:0] m_rd, m_nw;
    logic        m_err, got, addr_ok, rdy_ok, wd_ok;
    int          m_lat, g, we_seen;
    model(w, sz, sg, a, wd, ref_mem[a[5:2]], m_rd, m_err, m_lat, m_nw);
    g = 0;
    while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
    check({nm, "_ready_wait"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    got = 1'b0; addr_ok = 1'b1; rdy_ok = 1'b1; wd_ok = 1'b1; we_seen = 0;
    o_rd = 32'hDEAD_BEEF; o_err = 1'bx; o_lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (bus.mem_addr !== (a >> 2)) addr_ok = 1'b0;
      if (bus.req_ready !== 1'b0) rdy_ok = 1'b0;
      if (bus.mem_we === 1'b1) begin
        we_seen++;
        if (bus.mem_wdata !== m_nw) wd_ok = 1'b0;
      end
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1; o_lat = k; o_rd = bus.rsp_rdata; o_err = bus.rsp_err;
      end else begin
        @(negedge clk);
      end
    end
    check({nm, "_rsp_seen"}, {31'd0, got}, 32'd1);
    check({nm, "_we_pulses"}, we_seen, (w && !m_err) ? 32'd1 : 32'd0);
    check({nm, "_wdata"}, {31'd0, wd_ok}, 32'd1);
    check({nm, "_addr_hold"}, {31'd0, addr_ok}, 32'd1);
    check({nm, "_ready_busy"}, {31'd0, rdy_ok}, 32'd1);
    @(negedge clk);
    check({nm, "_post_idle"}, {29'd0, bus.rsp_valid, bus.req_ready, (bus.mem_addr != 0)}, 32'b010);
    if (w && !m_err) ref_mem[a[5:2]] = m_nw;
  endtask

  typedef struct {
    logic        pre;
    logic [31:0] pre_val;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] x_rd;
    logic        x_err;
    int          x_lat;
    string       nm;
  } vec_t;

  vec_t tab [12];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, m_rd, m_nw;
    logic        er, m_err;
    int          lat, m_lat, we0, nv, nw;
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    tab[0]  = '{1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 32'h4, 32'h0000_FA32, 32'h0,         1'b0, 2, "wst4"};
    tab[1]  = '{1'b0, 32'h0,         1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h0000_FA32, 1'b0, 2, "wld4"};
    tab[2]  = '{1'b1, 32'h1122_3344, 1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00AB, 32'h0,         1'b0, 3, "bst5"};
    tab[3]  = '{1'b0, 32'h0,         1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'h1122_AB44, 1'b0, 2, "wld_rmw"};
    tab[4]  = '{1'b1, 32'h80FF_0000, 1'b0, 2'd0, 1'b1, 32'h7, 32'h0,         32'hFFFF_FF80, 1'b0, 2, "sb7"};
    tab[5]  = '{1'b0, 32'h0,         1'b0, 2'd0, 1'b0, 32'h7, 32'h0,         32'h0000_0080, 1'b0, 2, "ub7"};
    tab[6]  = '{1'b0, 32'h0,         1'b0, 2'd1, 1'b1, 32'h6, 32'h0,         32'hFFFF_80FF, 1'b0, 2, "sh6"};
    tab[7]  = '{1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 32'h3, 32'h0000_5555, 32'h0,         1'b1, 1, "hst3_err"};
    tab[8]  = '{1'b0, 32'h0,         1'b0, 2'd3, 1'b0, 32'h0, 32'h0,         32'h0,         1'b1, 1, "sz11_err"};
    tab[9]  = '{1'b0, 32'h0,         1'b0, 2'd2, 1'b0, 32'h2, 32'h0,         32'h0,         1'b1, 1, "wld2_err"};
    tab[10] = '{1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 32'h6, 32'h1234_ABCD, 32'h0,         1'b0, 3, "hst6"};
    tab[11] = '{1'b0, 32'h0,         1'b0, 2'd2, 1'b0, 32'h4, 32'h0,         32'hABCD_0000, 1'b0, 2, "wld_hst"};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    #2;
    check("reset_outputs",
          {25'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_we,
           (bus.rsp_rdata != 0), (bus.mem_addr != 0), (bus.mem_wdata != 0)}, 32'd0);
    for (int i = 0; i < 16; i++) preset(4'(i), $urandom);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      if (tab[i].pre) preset(tab[i].a[5:2], tab[i].pre_val);
      run_req(tab[i].nm, tab[i].w, tab[i].sz, tab[i].sg, tab[i].a, tab[i].wd, rd, er, lat);
      check({tab[i].nm, "_rdata"}, rd, tab[i].x_rd);
      check({tab[i].nm, "_err"}, {31'd0, er}, {31'd0, tab[i].x_err});
      check({tab[i].nm, "_lat"}, lat, tab[i].x_lat);
    end
    check("ram1_after_table", ram[1], 32'hABCD_0000);

    // Reset during RD of a byte store: aborted, nothing written, no response.
    preset(4'd2, 32'hCAFE_BABE);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h9; bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    we0 = we_total;
    rst = 1'b0;
    #1;
    check("abort_outputs",
          {25'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_we,
           (bus.rsp_rdata != 0), (bus.mem_addr != 0), (bus.mem_wdata != 0)}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nv = 0; nw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) nv++;
      if (bus.mem_we) nw++;
    end
    check("abort_no_rsp", nv, 32'd0);
    check("abort_no_we", nw + (we_total - we0), 32'd0);
    check("abort_ram_kept", ram[2], 32'hCAFE_BABE);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);

    // Random requests against the model, including high addresses that wrap.
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_FFC0;
      wd = $urandom;
      model(w, sz, sg, a, wd, ref_mem[a[5:2]], m_rd, m_err, m_lat, m_nw);
      run_req($sformatf("rnd%0d", n), w, sz, sg, a, wd, rd, er, lat);
      check($sformatf("rnd%0d_rdata", n), rd, m_rd);
      check($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, m_err});
      check($sformatf("rnd%0d_lat", n), lat, m_lat);
    end
    for (int i = 0; i < 16; i++) check($sformatf("ram_final%0d", i), ram[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
